fft_ctrl: RTL

//  Sequencer for an in-place radix-2 DIT FFT built around one butterfly unit and a

---
 rtl/fft_ctrl_pkg.sv | 30 +++
 rtl/fft_addr_gen.sv | 47 ++++
 rtl/fft_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fft_ctrl_pkg
//   Shared definitions for the radix-2 DIT FFT sequencer: the FSM state
//   encoding, default parameter values and small helpers for derived sizes.
// -----------------------------------------------------------------------------
package fft_ctrl_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_LOG2N   = 4;
  localparam int DEF_MEM_LAT = 1;
  localparam int DEF_BF_LAT  = 1;

  // Width of the stage index port for a given LOG2N (at least one bit).
  function automatic int stage_width(input int log2n);
    return (log2n > 1) ? $clog2(log2n) : 1;
  endfunction

  // Cycles from the first RUN cycle to the DONE cycle.
  function automatic int total_cycles(input int log2n, input int mem_lat, input int bf_lat);
    return log2n * ((1 << (log2n - 1)) + mem_lat + bf_lat);
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// -----------------------------------------------------------------------------
// fft_addr_gen
//   Combinational butterfly address generator for an in-place radix-2 DIT FFT.
//   Ports:
//     s         in   stage index
//     k         in   butterfly index within the stage (0..N/2-1)
//     addr_a    out  upper-leg sample address
//     addr_b    out  lower-leg sample address (addr_a + half)
//     tw_addr   out  twiddle ROM index
// -----------------------------------------------------------------------------
module fft_addr_gen #(
  parameter int LOG2N = 4
) (
  input  logic [$clog2(LOG2N)-1:0] s,
  input  logic [LOG2N-2:0]         k,
  output logic [LOG2N-1:0]         addr_a,
  output logic [LOG2N-1:0]         addr_b,
  output logic [LOG2N-2:0]         tw_addr
);

  localparam int SW = $clog2(LOG2N);
  localparam int KW = LOG2N - 1;
  localparam logic [LOG2N-1:0] ONE_A = LOG2N'(1);
  localparam logic [SW-1:0]    TOP_S = SW'(LOG2N - 1);

  logic [LOG2N-1:0] half_s;
  logic [KW-1:0]    mask_s;
  logic [KW-1:0]    pos_s;
  logic [LOG2N-1:0] grp_s;
  logic [LOG2N-1:0] a_s;
  logic [SW-1:0]    sh_s;

  // Split k into group/position for stage s and form both legs and the twiddle index.
  always_comb begin
    half_s  = ONE_A << s;
    mask_s  = KW'(half_s - ONE_A);
    pos_s   = k & mask_s;
    grp_s   = {1'b0, k} >> s;
    // Two single shifts instead of << (s+1) so s+1 can never wrap in SW bits.
    a_s     = ((grp_s << s) << 1) | {1'b0, pos_s};
    sh_s    = TOP_S - s;
    addr_a  = a_s;
    addr_b  = a_s + half_s;
    tw_addr = pos_s << sh_s;
  end

endmodule

// File: rtl/fft_ctrl.sv
// -----------------------------------------------------------------------------
// fft_ctrl
//   Sequencer for an in-place radix-2 DIT FFT with one butterfly and a
//   dual-port sample memory. Runs LOG2N stages of N/2 butterflies, one per
//   cycle, then drains the MEM_LAT+BF_LAT pipeline before the next stage so
//   the last write of a stage lands before the first read of the next one.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     start                 request a transform (sampled only in IDLE)
//     busy                  high in RUN and DRAIN
//     done                  one-cycle pulse after the final write-back
//     stage                 current stage index
//     rd_en, rd_addr_a/b    memory read strobe and leg addresses
//     tw_addr               twiddle ROM index
//     bf_enable             butterfly enable (rd_en delayed MEM_LAT)
//     wr_en, wr_addr_a/b    write-back strobe/addresses (delayed MEM_LAT+BF_LAT)
// -----------------------------------------------------------------------------
module fft_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int LOG2N   = DEF_LOG2N,
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int BF_LAT  = DEF_BF_LAT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(LOG2N)-1:0] stage,
  output logic                     rd_en,
  output logic [LOG2N-1:0]         rd_addr_a,
  output logic [LOG2N-1:0]         rd_addr_b,
  output logic [LOG2N-2:0]         tw_addr,
  output logic                     bf_enable,
  output logic                     wr_en,
  output logic [LOG2N-1:0]         wr_addr_a,
  output logic [LOG2N-1:0]         wr_addr_b
);

  localparam int SW   = $clog2(LOG2N);
  localparam int KW   = LOG2N - 1;
  localparam int PIPE = MEM_LAT + BF_LAT;
  localparam int DW   = $clog2(PIPE + 1);

  localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);

  state_e        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] drain_q, drain_d;

  logic [LOG2N-1:0] gen_a_s, gen_b_s;
  logic [KW-1:0]    gen_tw_s;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG2N-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [LOG2N-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [KW-1:0]    tw_addr_q, tw_addr_d;

  // Delay lines: index 0 is one cycle behind rd_*, index PIPE-1 feeds wr_*.
  logic [PIPE-1:0]  en_sr_q, en_sr_d;
  logic [LOG2N-1:0] wa_sr_q [PIPE];
  logic [LOG2N-1:0] wa_sr_d [PIPE];
  logic [LOG2N-1:0] wb_sr_q [PIPE];
  logic [LOG2N-1:0] wb_sr_d [PIPE];

  // Addresses are generated from the next (s, k) so they register alongside rd_en.
  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .s       (s_d),
    .k       (k_d),
    .addr_a  (gen_a_s),
    .addr_b  (gen_b_s),
    .tw_addr (gen_tw_s)
  );

  // FSM state and stage/butterfly/drain counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= {SW{1'b0}};
      k_q     <= {KW{1'b0}};
      drain_q <= {DW{1'b0}};
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      drain_q <= drain_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          s_d     = {SW{1'b0}};
          k_d     = {KW{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (k_q == K_LAST) begin
          state_d = ST_DRAIN;
          drain_d = {DW{1'b0}};
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      ST_DRAIN: begin
        if (drain_q == D_LAST) begin
          if (s_q == S_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            s_d     = s_q + S_ONE;
            k_d     = {KW{1'b0}};
          end
        end else begin
          drain_d = drain_q + D_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        s_d     = {SW{1'b0}};
        k_d     = {KW{1'b0}};
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = {SW{1'b0}};
        k_d     = {KW{1'b0}};
        drain_d = {DW{1'b0}};
      end
    endcase
  end

  // Output decode from the next state, so registered outputs line up with state_q.
  always_comb begin
    busy_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);
    rd_en_d = (state_d == ST_RUN);
    stage_d = s_d;
    if (rd_en_d) begin
      rd_addr_a_d = gen_a_s;
      rd_addr_b_d = gen_b_s;
      tw_addr_d   = gen_tw_s;
    end else begin
      rd_addr_a_d = rd_addr_a_q;
      rd_addr_b_d = rd_addr_b_q;
      tw_addr_d   = tw_addr_q;
    end
    en_sr_d[0] = rd_en_q;
    wa_sr_d[0] = rd_addr_a_q;
    wb_sr_d[0] = rd_addr_b_q;
    for (int i = 1; i < PIPE; i++) begin
      en_sr_d[i] = en_sr_q[i-1];
      wa_sr_d[i] = wa_sr_q[i-1];
      wb_sr_d[i] = wb_sr_q[i-1];
    end
  end

  // Output registers and write-back delay lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stage_q     <= {SW{1'b0}};
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= {LOG2N{1'b0}};
      rd_addr_b_q <= {LOG2N{1'b0}};
      tw_addr_q   <= {KW{1'b0}};
      en_sr_q     <= {PIPE{1'b0}};
      for (int i = 0; i < PIPE; i++) begin
        wa_sr_q[i] <= {LOG2N{1'b0}};
        wb_sr_q[i] <= {LOG2N{1'b0}};
      end
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      stage_q     <= stage_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_addr_q   <= tw_addr_d;
      en_sr_q     <= en_sr_d;
      for (int i = 0; i < PIPE; i++) begin
        wa_sr_q[i] <= wa_sr_d[i];
        wb_sr_q[i] <= wb_sr_d[i];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = stage_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign tw_addr   = tw_addr_q;
  assign bf_enable = en_sr_q[MEM_LAT-1];
  assign wr_en     = en_sr_q[PIPE-1];
  assign wr_addr_a = wa_sr_q[PIPE-1];
  assign wr_addr_b = wb_sr_q[PIPE-1];

endmodule
